// File: rtl/vector_stream_pkg.sv
// Shared defaults and types for the vector result streamer.
// The SUM state exists in the enum whether or not VECTOR_STREAM_SUM_EN is defined.
`timescale 1ns/1ps
package vector_stream_pkg;

  localparam int VEC_LEN = 5;
  localparam int DATA_W  = 32;

  typedef logic signed [DATA_W-1:0] elem_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    SUM    = 2'd2
  } strm_state_e;

endpackage

// File: rtl/vector_result_streamer.sv
// Captures a parallel result vector in one handshake and replays it as a serial
// valid/ready stream; define VECTOR_STREAM_SUM_EN to append a running-sum beat.
`timescale 1ns/1ps
module vector_result_streamer #(
  parameter int VEC_LEN = vector_stream_pkg::VEC_LEN,
  parameter int DATA_W  = vector_stream_pkg::DATA_W,
  localparam int IDX_W  = $clog2(VEC_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_vec [VEC_LEN],
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]         out_idx,
  output logic                     out_last,
  output logic                     busy,
  output logic [1:0]               dbg_state
);

  import vector_stream_pkg::*;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
  // valid never depends combinationally on ready; data/idx/last are stable while valid && !ready.

  localparam logic [1:0]       ST_IDLE   = IDLE;
  localparam logic [1:0]       ST_STREAM = STREAM;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(VEC_LEN - 1);
`ifdef VECTOR_STREAM_SUM_EN
  localparam logic [1:0]       ST_SUM    = SUM;
  localparam logic [IDX_W-1:0] SUM_IDX   = IDX_W'(VEC_LEN);
`endif

  logic [1:0]               state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic signed [DATA_W-1:0] buf_q [VEC_LEN];
  logic                     capture;
  logic                     beat_accept;

  assign beat_accept = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
`ifdef VECTOR_STREAM_SUM_EN
            state_d = ST_SUM;
`else
            state_d = ST_IDLE;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef VECTOR_STREAM_SUM_EN
      ST_SUM: begin
        if (out_ready) state_d = ST_IDLE;
      end
`endif
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // The buffer carries no reset: its contents only matter after a capture.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < VEC_LEN; i++) buf_q[i] <= in_vec[i];
    end
  end

`ifdef VECTOR_STREAM_SUM_EN
  logic signed [DATA_W-1:0] acc_q;

  // Wraps at DATA_W bits; the sum beat reports the two's-complement result.
  always_ff @(posedge clk) begin
    if (rst || capture) begin
      acc_q <= '0;
    end else if (beat_accept && state_q == ST_STREAM) begin
      acc_q <= acc_q + out_data;
    end
  end
`endif

  always_comb begin
    out_data = '0;
    out_idx  = '0;
    out_last = 1'b0;
    if (state_q == ST_STREAM) begin
      out_data = buf_q[idx_q];
      out_idx  = idx_q;
`ifndef VECTOR_STREAM_SUM_EN
      out_last = (idx_q == LAST_IDX);
`endif
    end
`ifdef VECTOR_STREAM_SUM_EN
    if (state_q == ST_SUM) begin
      out_data = acc_q;
      out_idx  = SUM_IDX;
      out_last = 1'b1;
    end
`endif
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q != ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_vector_result_streamer.sv
// Bench for vector_result_streamer: queue-based beat model checked every cycle,
// plus directed vectors with literal expectations.
`timescale 1ns/1ps
module tb_vector_result_streamer;

  localparam int VL = 5;
  localparam int DW = 32;
`ifdef VECTOR_STREAM_SUM_EN
  localparam bit SUM_ON = 1'b1;
`else
  localparam bit SUM_ON = 1'b0;
`endif
  localparam int BEATS  = VL + (SUM_ON ? 1 : 0);
  localparam int PERIOD = BEATS + 1;

  typedef struct {
    logic signed [DW-1:0] d;
    int                   idx;
    bit                   last;
  } beat_t;

  // ---------------- clock / reset / DUT ----------------
  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_vec [VL];
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic signed [DW-1:0] out_data;
  logic [2:0]           out_idx;
  logic                 out_last;
  logic                 busy;
  logic [1:0]           dbg_state;

  always #5 clk = ~clk;

  vector_result_streamer #(.VEC_LEN(VL), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  bit    armed = 1'b0;
  beat_t mq[$];
  beat_t lg[$];
  int    lg_cyc[$];
  logic signed [DW-1:0] vec_tmp [VL];
  logic signed [DW-1:0] ea [VL];

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: a vector becomes a list of pending beats when accepted while idle;
  // each accepted beat removes the head; reset forgets everything.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      mq.delete();
      armed = 1'b1;
    end else if (mq.size() == 0) begin
      if (in_valid) begin
        beat_t b;
        logic signed [DW-1:0] s;
        s = '0;
        for (int j = 0; j < VL; j++) begin
          b.d    = in_vec[j];
          b.idx  = j;
          b.last = !SUM_ON && (j == VL - 1);
          mq.push_back(b);
          s = s + in_vec[j];
        end
        if (SUM_ON) begin
          b.d    = s;
          b.idx  = VL;
          b.last = 1'b1;
          mq.push_back(b);
        end
      end
    end else if (out_ready) begin
      void'(mq.pop_front());
    end
  end

  // Compare process plus log of accepted beats.
  always @(negedge clk) begin
    if (armed) begin
      if (mq.size() != 0) begin
        chk("m_valid", out_valid, 1);
        chk("m_data", out_data, mq[0].d);
        chk("m_idx", out_idx, mq[0].idx);
        chk("m_last", out_last, mq[0].last);
        chk("m_in_ready", in_ready, 0);
        chk("m_busy", busy, 1);
      end else begin
        chk("m_valid_idle", out_valid, 0);
        chk("m_data_idle", out_data, 0);
        chk("m_idx_idle", out_idx, 0);
        chk("m_last_idle", out_last, 0);
        chk("m_in_ready_idle", in_ready, 1);
        chk("m_busy_idle", busy, 0);
      end
      if (out_valid === 1'b1 && out_ready && !rst) begin
        lg.push_back('{d: out_data, idx: int'(out_idx), last: out_last});
        lg_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_vec(input logic signed [DW-1:0] a, b, c, d, e);
    vec_tmp[0] = a; vec_tmp[1] = b; vec_tmp[2] = c; vec_tmp[3] = d; vec_tmp[4] = e;
  endtask

  task automatic send(output int p);
    @(posedge clk); #1;
    for (int j = 0; j < VL; j++) in_vec[j] = vec_tmp[j];
    in_valid = 1'b1;
    p = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (mq.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", mq.size(), 0);
  endtask

  task automatic wait_for_idx(input int k, input int budget);
    bit found;
    found = 1'b0;
    for (int n = 0; n < budget && !found; n++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1 && int'(out_idx) == k) found = 1'b1;
    end
    chk("idx_seen", found, 1);
  endtask

  task automatic clear_log();
    lg.delete();
    lg_cyc.delete();
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int p;
    int t0, tg;
    for (int j = 0; j < VL; j++) in_vec[j] = '0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_state", dbg_state, 0);

    // Full-throughput stream with extreme values.
    ea[0] = 32'sd3; ea[1] = -32'sd7; ea[2] = 32'sd0;
    ea[3] = 32'sh7FFF_FFFF; ea[4] = 32'sh8000_0000;
    clear_log();
    set_vec(32'sd3, -32'sd7, 32'sd0, 32'sh7FFF_FFFF, 32'sh8000_0000);
    send(p);
    wait_idle(40);
    chk("t1_count", lg.size(), BEATS);
    if (lg.size() == BEATS) begin
      for (int i = 0; i < VL; i++) begin
        chk("t1_data", lg[i].d, ea[i]);
        chk("t1_idx", lg[i].idx, i);
        chk("t1_last", lg[i].last, (i == VL - 1) ? !SUM_ON : 1'b0);
        chk("t1_cycle", lg_cyc[i], p + 1 + i);
      end
`ifdef VECTOR_STREAM_SUM_EN
      chk("t1_sum", lg[VL].d, -5);
      chk("t1_sum_idx", lg[VL].idx, 5);
      chk("t1_sum_last", lg[VL].last, 1);
`endif
    end

    // Stall three cycles on element 2 (value 0).
    clear_log();
    send(p);
    wait_for_idx(2, 20);
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t2_hold_valid", out_valid, 1);
      chk("t2_hold_data", out_data, 0);
      chk("t2_hold_idx", out_idx, 2);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_idle(40);
    chk("t2_count", lg.size(), BEATS);
    if (lg.size() == BEATS) begin
      for (int i = 0; i < VL; i++) begin
        chk("t2_data", lg[i].d, ea[i]);
        chk("t2_idx", lg[i].idx, i);
      end
    end

    // in_valid held high with in_vec changing every cycle: element j = tag*16 + j.
    clear_log();
    for (int k = 0; k < 2 * PERIOD + 1; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      for (int j = 0; j < VL; j++) in_vec[j] = DW'(cyc * 16 + j);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_idle(60);
    chk("t3_count", lg.size(), 3 * BEATS);
    if (lg.size() == 3 * BEATS) begin
      for (int g = 0; g < 3; g++) begin
        tg = int'(lg[g * BEATS].d) / 16;
        for (int j = 0; j < VL; j++) begin
          chk("t3_idx", lg[g * BEATS + j].idx, j);
          chk("t3_tag", int'(lg[g * BEATS + j].d) / 16, tg);
          chk("t3_elem", int'(lg[g * BEATS + j].d) % 16, j);
        end
        if (g > 0) begin
          chk("t3_tag_step", tg - t0, PERIOD);
          chk("t3_idle_gap", lg_cyc[g * BEATS] - lg_cyc[g * BEATS - 1], 2);
        end
        t0 = tg;
      end
    end

    // Reset after element 1 has been accepted.
    clear_log();
    set_vec(32'sd3, -32'sd7, 32'sd0, 32'sh7FFF_FFFF, 32'sh8000_0000);
    send(p);
    wait_for_idx(2, 20);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t4_out_valid", out_valid, 0);
    chk("t4_busy", busy, 0);
    chk("t4_in_ready", in_ready, 1);
    chk("t4_partial_count", lg.size(), 2);
    for (int i = 0; i < lg.size(); i++) chk("t4_no_last", lg[i].last, 0);
    clear_log();
    send(p);
    wait_idle(40);
    chk("t4_restart_count", lg.size(), BEATS);
    if (lg.size() == BEATS) begin
      chk("t4_first_idx", lg[0].idx, 0);
      chk("t4_first_data", lg[0].d, 3);
      chk("t4_elem4", lg[4].d, 32'sh8000_0000);
    end

    // Small values, then a wrapping sum when the sum beat is built in.
    clear_log();
    set_vec(32'sd1, 32'sd2, 32'sd3, 32'sd4, 32'sd5);
    send(p);
    wait_idle(40);
    chk("t5_count", lg.size(), BEATS);
    if (lg.size() == BEATS) begin
`ifdef VECTOR_STREAM_SUM_EN
      chk("t5_e4_last", lg[4].last, 0);
      chk("t5_sum", lg[5].d, 15);
      chk("t5_sum_idx", lg[5].idx, 5);
      chk("t5_sum_last", lg[5].last, 1);
`else
      chk("t5_e4_last", lg[4].last, 1);
      chk("t5_e4_data", lg[4].d, 5);
`endif
    end

    clear_log();
    set_vec(32'sh7FFF_FFFF, 32'sd1, 32'sd0, 32'sd0, 32'sd0);
    send(p);
    wait_idle(40);
    chk("t6_count", lg.size(), BEATS);
    if (lg.size() == BEATS) begin
      chk("t6_e0", lg[0].d, 32'sh7FFF_FFFF);
      chk("t6_e1", lg[1].d, 1);
`ifdef VECTOR_STREAM_SUM_EN
      chk("t6_sum_wrap", lg[5].d, 32'sh8000_0000);
`endif
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
